// File: rtl/sram_pingpong_ctrl_pkg.sv
// ============================================================================
// Module      : sram_pingpong_ctrl_pkg
// Description : Shared widths, bit-mask and macro control encodings for the
//               SRAM ping-pong controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pingpong_ctrl_pkg;

    localparam int unsigned c_DATA_W_DEF = 32;
    localparam int unsigned c_ADDR_W_DEF = 8;
    localparam int unsigned c_MACRO_DW   = 48;

    localparam logic [c_MACRO_DW-1:0] c_BM_ALL = '1;

    typedef struct packed {
        logic men;
        logic wen;
        logic ren;
    } mctl_t;

    localparam mctl_t c_MCTL_IDLE  = '{men: 1'b0, wen: 1'b0, ren: 1'b0};
    localparam mctl_t c_MCTL_WRITE = '{men: 1'b1, wen: 1'b1, ren: 1'b0};
    localparam mctl_t c_MCTL_READ  = '{men: 1'b1, wen: 1'b0, ren: 1'b1};

    function automatic logic [1:0] f_popcount2(input logic [1:0] i_v);
        return {1'b0, i_v[0]} + {1'b0, i_v[1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_pingpong_ctrl_if.sv
// ============================================================================
// Module      : sram_pingpong_ctrl_if
// Description : Writer/reader handshake bundle between the datapath (master)
//               and the ping-pong controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_pingpong_ctrl_if
    import sram_pingpong_ctrl_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    modport master (
        output wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_last,
        input  wr_ready, rd_ready, rd_data, rd_data_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_last,
        output wr_ready, rd_ready, rd_data, rd_data_valid
    );

endinterface

`default_nettype wire

// File: rtl/sram_pingpong_ctrl_bank_port_mux.sv
// ============================================================================
// Module      : sram_bank_port_mux
// Description : Per-macro pin driver; routes the writer or reader access to
//               this macro when its pointer selects bank BANK, else idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank_port_mux
    import sram_pingpong_ctrl_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W_DEF,
    parameter int DATA_W   = c_DATA_W_DEF,
    parameter int MACRO_DW = c_MACRO_DW,
    parameter bit BANK     = 1'b0
) (
    input  wire logic              i_wr_ptr,
    input  wire logic              i_rd_ptr,
    input  wire logic              i_wa,
    input  wire logic              i_ra,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    input  wire logic [DATA_W-1:0] i_wr_data,
    output mctl_t                  o_ctl,
    output logic [ADDR_W-1:0]      o_addr,
    output logic [MACRO_DW-1:0]    o_din
);

    logic w_wr_hit;
    logic w_rd_hit;

    assign w_wr_hit = i_wa && (i_wr_ptr == BANK);
    assign w_rd_hit = i_ra && (i_rd_ptr == BANK);

    // Write bank is never full and read bank always is, so both hits never coincide.
    always_comb begin
        o_ctl  = c_MCTL_IDLE;
        o_addr = '0;
        o_din  = '0;
        if (w_wr_hit) begin
            o_ctl  = c_MCTL_WRITE;
            o_addr = i_wr_addr;
            o_din  = MACRO_DW'(i_wr_data) & MACRO_DW'(c_BM_ALL);
        end else if (w_rd_hit) begin
            o_ctl  = c_MCTL_READ;
            o_addr = i_rd_addr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_pingpong_ctrl.sv
// ============================================================================
// Module      : sram_pingpong_ctrl
// Description : Frame ping-pong controller over two single-port SRAM macros.
//               Optional drop counters: define PINGPONG_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_pingpong_ctrl
    import sram_pingpong_ctrl_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEF,
    parameter int ADDR_W   = c_ADDR_W_DEF,
    parameter int MACRO_DW = c_MACRO_DW
) (
    input  wire logic                clk,
    input  wire logic                rst,
    sram_pingpong_ctrl_if.slave      bus,
    output logic                     o_wr_bank,
    output logic                     o_rd_bank,
    output logic [1:0]               o_fill_level,
    output logic                     o_m0_men,
    output logic                     o_m0_wen,
    output logic                     o_m0_ren,
    output logic [ADDR_W-1:0]        o_m0_addr,
    output logic [MACRO_DW-1:0]      o_m0_din,
    input  wire logic [MACRO_DW-1:0] i_m0_dout,
    output logic                     o_m1_men,
    output logic                     o_m1_wen,
    output logic                     o_m1_ren,
    output logic [ADDR_W-1:0]        o_m1_addr,
    output logic [MACRO_DW-1:0]      o_m1_din,
    input  wire logic [MACRO_DW-1:0] i_m1_dout
`ifdef PINGPONG_OVF_CNT_EN
    ,
    output logic [15:0]              o_wr_drop_cnt,
    output logic [15:0]              o_rd_drop_cnt
`endif
);

    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_full;
    logic              r_rd_sel;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_wr_ready;
    logic              w_rd_ready;
    logic              w_wa;
    logic              w_ra;
    logic [1:0]        w_full_nxt;
    logic [DATA_W-1:0] w_dout_sel;

    mctl_t             w_ctl   [2];
    logic [ADDR_W-1:0] w_maddr [2];
    logic [MACRO_DW-1:0] w_mdin [2];

    assign w_wr_ready = !r_full[r_wr_ptr];
    assign w_rd_ready = r_full[r_rd_ptr];
    assign w_wa       = bus.wr_en && w_wr_ready;
    assign w_ra       = bus.rd_en && w_rd_ready;

    always_comb begin
        w_full_nxt = r_full;
        if (w_wa && bus.wr_last) w_full_nxt[r_wr_ptr] = 1'b1;
        if (w_ra && bus.rd_last) w_full_nxt[r_rd_ptr] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_full     <= 2'b00;
            r_rd_sel   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_full     <= w_full_nxt;
            r_rd_valid <= w_ra;
            if (w_wa && bus.wr_last) r_wr_ptr <= ~r_wr_ptr;
            if (w_ra && bus.rd_last) r_rd_ptr <= ~r_rd_ptr;
            if (w_ra) r_rd_sel <= r_rd_ptr;
            if (r_rd_valid) r_rd_data <= w_dout_sel;
        end
    end

    // Macro dout is only valid in the cycle after the access; r_rd_data holds it afterwards.
    assign w_dout_sel        = r_rd_sel ? i_m1_dout[DATA_W-1:0] : i_m0_dout[DATA_W-1:0];
    assign bus.rd_data       = r_rd_valid ? w_dout_sel : r_rd_data;
    assign bus.rd_data_valid = r_rd_valid;
    assign bus.wr_ready      = w_wr_ready;
    assign bus.rd_ready      = w_rd_ready;
    assign o_wr_bank         = r_wr_ptr;
    assign o_rd_bank         = r_rd_ptr;
    assign o_fill_level      = f_popcount2(r_full);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        sram_bank_port_mux #(
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .MACRO_DW (MACRO_DW),
            .BANK     (gi == 1)
        ) u_mux (
            .i_wr_ptr  (r_wr_ptr),
            .i_rd_ptr  (r_rd_ptr),
            .i_wa      (w_wa),
            .i_ra      (w_ra),
            .i_wr_addr (bus.wr_addr),
            .i_rd_addr (bus.rd_addr),
            .i_wr_data (bus.wr_data),
            .o_ctl     (w_ctl[gi]),
            .o_addr    (w_maddr[gi]),
            .o_din     (w_mdin[gi])
        );
    end

    assign {o_m0_men, o_m0_wen, o_m0_ren} = w_ctl[0];
    assign o_m0_addr                      = w_maddr[0];
    assign o_m0_din                       = w_mdin[0];
    assign {o_m1_men, o_m1_wen, o_m1_ren} = w_ctl[1];
    assign o_m1_addr                      = w_maddr[1];
    assign o_m1_din                       = w_mdin[1];

    if (DATA_W < MACRO_DW) begin : g_dout_unused
        logic w_unused_dout;
        assign w_unused_dout = ^{i_m0_dout[MACRO_DW-1:DATA_W], i_m1_dout[MACRO_DW-1:DATA_W]};
    end

`ifdef PINGPONG_OVF_CNT_EN
    logic [15:0] r_wr_drop_cnt;
    logic [15:0] r_rd_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_drop_cnt <= '0;
            r_rd_drop_cnt <= '0;
        end else begin
            if (bus.wr_en && !w_wr_ready && (r_wr_drop_cnt != 16'hFFFF))
                r_wr_drop_cnt <= r_wr_drop_cnt + 16'd1;
            if (bus.rd_en && !w_rd_ready && (r_rd_drop_cnt != 16'hFFFF))
                r_rd_drop_cnt <= r_rd_drop_cnt + 16'd1;
        end
    end

    assign o_wr_drop_cnt = r_wr_drop_cnt;
    assign o_rd_drop_cnt = r_rd_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_pingpong_ctrl.sv
// ============================================================================
// Module      : tb_sram_pingpong_ctrl
// Description : Directed bench with behavioural macros and a read scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_pingpong_ctrl;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int MACRO_DW = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_pingpong_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    logic                wr_bank, rd_bank;
    logic [1:0]          fill_level;
    logic                m0_men, m0_wen, m0_ren, m1_men, m1_wen, m1_ren;
    logic [ADDR_W-1:0]   m0_addr, m1_addr;
    logic [MACRO_DW-1:0] m0_din, m1_din, m0_dout, m1_dout;
`ifdef PINGPONG_OVF_CNT_EN
    logic [15:0]         wr_drop_cnt, rd_drop_cnt;
`endif

    sram_pingpong_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MACRO_DW(MACRO_DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .o_wr_bank    (wr_bank),
        .o_rd_bank    (rd_bank),
        .o_fill_level (fill_level),
        .o_m0_men     (m0_men),
        .o_m0_wen     (m0_wen),
        .o_m0_ren     (m0_ren),
        .o_m0_addr    (m0_addr),
        .o_m0_din     (m0_din),
        .i_m0_dout    (m0_dout),
        .o_m1_men     (m1_men),
        .o_m1_wen     (m1_wen),
        .o_m1_ren     (m1_ren),
        .o_m1_addr    (m1_addr),
        .o_m1_din     (m1_din),
        .i_m1_dout    (m1_dout)
`ifdef PINGPONG_OVF_CNT_EN
        ,
        .o_wr_drop_cnt(wr_drop_cnt),
        .o_rd_drop_cnt(rd_drop_cnt)
`endif
    );

    // Behavioural single-port macros with registered read data
    logic [MACRO_DW-1:0] mem0 [256];
    logic [MACRO_DW-1:0] mem1 [256];
    always @(posedge clk) begin
        if (m0_men && m0_wen) mem0[m0_addr] <= m0_din;
        if (m0_men && m0_ren) m0_dout <= mem0[m0_addr];
        if (m1_men && m1_wen) mem1[m1_addr] <= m1_din;
        if (m1_men && m1_ren) m1_dout <= mem1[m1_addr];
    end

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;
    sb_t sb[$];

    // Reference model state
    logic [31:0] exp_mem [2][256];
    logic        m_wp, m_rp;
    logic [1:0]  m_full;
    logic [31:0] last_rd;
    logic        mon_en = 1'b0;
    int          m_wdrop, m_rdrop;

    always @(negedge clk) begin
        if (mon_en) begin
            automatic logic exp_v = (sb.size() > 0) && (sb[0].due == cycle_no);
            checks++;
            assert (bus.rd_data_valid === exp_v) else begin
                errors++;
                $error("FAIL rd_valid cyc=%0d got=%b exp=%b", cycle_no, bus.rd_data_valid, exp_v);
            end
            if (exp_v) begin
                automatic sb_t e = sb.pop_front();
                checks++;
                assert (bus.rd_data === e.data) else begin
                    errors++;
                    $error("FAIL rd_data cyc=%0d got=%h exp=%h", cycle_no, bus.rd_data, e.data);
                end
                last_rd = e.data;
            end else begin
                checks++;
                assert (bus.rd_data === last_rd) else begin
                    errors++;
                    $error("FAIL rd_hold cyc=%0d got=%h exp=%h", cycle_no, bus.rd_data, last_rd);
                end
            end
        end
    end

    task automatic do_reset();
        mon_en      = 1'b0;
        bus.wr_en   = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 1'b0;
        bus.rd_en   = 1'b0; bus.rd_addr = '0; bus.rd_last = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_wp = 1'b0; m_rp = 1'b0; m_full = 2'b00; last_rd = '0;
        m_wdrop = 0; m_rdrop = 0;
        sb.delete();
        checks++;
        assert ({bus.rd_data_valid, bus.rd_data} === 33'h0) else begin
            errors++;
            $error("FAIL rst_rd got=%b/%h exp=0/0", bus.rd_data_valid, bus.rd_data);
        end
        mon_en = 1'b1;
    endtask

    // One clock of stimulus; checks status and both macro pin sets against the model.
    task automatic cyc(input bit we, input logic [7:0] wa, input logic [31:0] wd, input bit wl,
                       input bit re, input logic [7:0] ra, input bit rl);
        logic       acc_w, acc_r;
        logic [5:0] exp_st, got_st;
        logic [58:0] exp_p [2];
        logic [58:0] got_p [2];
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_last = wl;
        bus.rd_en = re; bus.rd_addr = ra; bus.rd_last = rl;
        @(negedge clk);
        acc_w  = we && !m_full[m_wp];
        acc_r  = re && m_full[m_rp];
        exp_st = {!m_full[m_wp], m_full[m_rp], m_wp, m_rp,
                  {1'b0, m_full[0]} + {1'b0, m_full[1]}};
        got_st = {bus.wr_ready, bus.rd_ready, wr_bank, rd_bank, fill_level};
        checks++;
        assert (got_st === exp_st) else begin
            errors++;
            $error("FAIL status cyc=%0d got=%b exp=%b", cycle_no, got_st, exp_st);
        end
        got_p[0] = {m0_men, m0_wen, m0_ren, m0_addr, m0_din};
        got_p[1] = {m1_men, m1_wen, m1_ren, m1_addr, m1_din};
        for (int b = 0; b < 2; b++) begin
            exp_p[b] = '0;
            if (acc_w && (m_wp == b[0]))      exp_p[b] = {3'b110, wa, 16'h0, wd};
            else if (acc_r && (m_rp == b[0])) exp_p[b] = {3'b101, ra, 48'h0};
            checks++;
            assert (got_p[b] === exp_p[b]) else begin
                errors++;
                $error("FAIL pins_m%0d cyc=%0d got=%h exp=%h", b, cycle_no, got_p[b], exp_p[b]);
            end
        end
`ifdef PINGPONG_OVF_CNT_EN
        checks++;
        assert ({wr_drop_cnt, rd_drop_cnt} === {16'(m_wdrop), 16'(m_rdrop)}) else begin
            errors++;
            $error("FAIL drop_cnt got=%0d/%0d exp=%0d/%0d", wr_drop_cnt, rd_drop_cnt, m_wdrop, m_rdrop);
        end
        if (we && !acc_w) m_wdrop++;
        if (re && !acc_r) m_rdrop++;
`endif
        if (acc_r) sb.push_back('{data: exp_mem[m_rp][ra], due: cycle_no + 1});
        if (acc_w) exp_mem[m_wp][wa] = wd;
        if (acc_w && wl) begin m_full[m_wp] = 1'b1; m_wp = ~m_wp; end
        if (acc_r && rl) begin m_full[m_rp] = 1'b0; m_rp = ~m_rp; end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h0, 32'h0, 0, 0, 8'h0, 0);
    endtask

    initial begin
        do_reset();
        idle(2);

        // Single 4-word frame into bank 0, then drain it
        for (int i = 0; i < 4; i++) cyc(1, 8'(i), 32'hA0 + 32'(i), i == 3, 0, 8'h0, 0);
        idle(1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h0, 32'h0, 0, 1, 8'(i), i == 3);
        idle(2);

        // Fill both banks with 2-word frames, then hammer the full writer
        for (int i = 0; i < 2; i++) cyc(1, 8'(i), 32'hB0 + 32'(i), i == 1, 0, 8'h0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 8'(i), 32'hC0 + 32'(i), i == 1, 0, 8'h0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'h0, 32'hDEAD0000 + 32'(i), 1, 0, 8'h0, 0);

        // Drain bank 1, then concurrent drain of bank 0 / fill of bank 1 with coincident lasts
        for (int i = 0; i < 2; i++) cyc(0, 8'h0, 32'h0, 0, 1, 8'(i), i == 1);
        for (int i = 0; i < 2; i++) cyc(1, 8'(i), 32'hD0 + 32'(i), i == 1, 1, 8'(i), i == 1);
        idle(1);
        for (int i = 0; i < 2; i++) cyc(0, 8'h0, 32'h0, 0, 1, 8'(i), i == 1);
        idle(1);

        // Reads with nothing buffered are dropped
        for (int i = 0; i < 2; i++) cyc(0, 8'h0, 32'h0, 0, 1, 8'(i), 1);
        idle(1);

        // Reset in the middle of a frame, then a 1-word frame
        for (int i = 0; i < 2; i++) cyc(1, 8'(i), 32'hE0 + 32'(i), 0, 0, 8'h0, 0);
        do_reset();
        idle(1);
        cyc(1, 8'h5, 32'h0000_00F5, 1, 0, 8'h0, 0);
        cyc(0, 8'h0, 32'h0, 0, 1, 8'h5, 1);
        idle(3);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain got=%0d exp=0 pending reads", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
